// File: rtl/td4_clk_pkg.sv
// td4_clk_pkg: mode encoding, speed-select width and default tick rates for the TD4 clock sequencer.
package td4_clk_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALTED = 2'd2} clk_mode_t;
    localparam int SPEED_W = 2;
    localparam logic [31:0] RATE0_DEF = 32'd100_000_000;
    localparam logic [31:0] RATE1_DEF = 32'd10_000_000;
    localparam logic [31:0] RATE2_DEF = 32'd1_000_000;
    localparam logic [31:0] RATE3_DEF = 32'd1;
    localparam int unsigned DEBOUNCE_DEF = 1_000_000;
    // A zero rate behaves as one tick per cycle.
    function automatic logic [31:0] last_count(input logic [31:0] r);
        return (r == 32'd0) ? 32'd0 : r - 32'd1;
    endfunction
endpackage

// File: rtl/step_conditioner.sv
// step_conditioner: 2-flop sync, optional debounce (CPU_CLOCK_CTRL_DEBOUNCE_EN) and rising-edge pulse
// for the manual step button.
module step_conditioner
    import td4_clk_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic pulse
);
    logic [1:0] sync_q;
    logic       level;
    logic       prev_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn};
            prev_q <= level;
        end
    end
`ifdef CPU_CLOCK_CTRL_DEBOUNCE_EN
    logic        level_q, level_d;
    logic [31:0] cnt_q, cnt_d;
    // cnt_q counts consecutive cycles the synchronized input disagrees with the accepted level.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q + 32'd1 >= DEBOUNCE_CYCLES) level_d = sync_q[1];
            else cnt_d = cnt_q + 32'd1;
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end
    assign level = level_q;
`else
    assign level = sync_q[1];
`endif
    assign pulse = level & ~prev_q;
endmodule

// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl: TD4 clock-enable sequencer (free-run at 4 rates, manual step, halt).
// Step-button debounce is enabled by defining CPU_CLOCK_CTRL_DEBOUNCE_EN.
module cpu_clock_ctrl
    import td4_clk_pkg::*;
#(
    parameter logic [31:0]  RATE0           = RATE0_DEF,
    parameter logic [31:0]  RATE1           = RATE1_DEF,
    parameter logic [31:0]  RATE2           = RATE2_DEF,
    parameter logic [31:0]  RATE3           = RATE3_DEF,
    parameter int unsigned  DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               run_sw,
    input  logic               step_btn,
    input  logic [SPEED_W-1:0] speed_sel,
    input  logic               halt_req,
    output logic               cpu_tick,
    output logic               tick_led,
    output logic [1:0]         mode
);
    clk_mode_t          state_q, state_d;
    logic [31:0]        div_q, div_d, last;
    logic [SPEED_W-1:0] spd_q;
    logic [1:0]         run_q;
    logic               tick_q, tick_d, led_q, step_pulse, run_sync;

    step_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
        .clock (clock),
        .reset (reset),
        .btn   (step_btn),
        .pulse (step_pulse)
    );

    assign run_sync = run_q[1];
    assign last = last_count(speed_sel == 2'd0 ? RATE0 :
                             speed_sel == 2'd1 ? RATE1 :
                             speed_sel == 2'd2 ? RATE2 : RATE3);

    // Priority in RUN: leave on run_sw=0, then halt, then rate change, then terminal count.
    always_comb begin
        state_d = state_q;
        div_d   = '0;
        tick_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (run_sync) state_d = RUN;
                else tick_d = step_pulse;
            end
            RUN: begin
                if (!run_sync) state_d = IDLE;
                else if (halt_req) state_d = HALTED;
                else if (speed_sel == spd_q) begin
                    tick_d = (div_q == last);
                    div_d  = (div_q >= last) ? '0 : div_q + 32'd1;
                end
            end
            HALTED: begin
                if (!run_sync) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            spd_q   <= '0;
            run_q   <= '0;
            tick_q  <= 1'b0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            spd_q   <= speed_sel;
            run_q   <= {run_q[0], run_sw};
            tick_q  <= tick_d;
            led_q   <= led_q ^ tick_d;
        end
    end

    assign cpu_tick = tick_q;
    assign tick_led = led_q;
    assign mode     = state_q;
endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// tb_cpu_clock_ctrl: randomized and directed checks of cpu_clock_ctrl against a cycle-level reference model.
module tb_cpu_clock_ctrl;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       run_sw = 1'b0;
    logic       step_btn = 1'b0;
    logic       halt_req = 1'b0;
    logic [1:0] speed_sel = 2'd0;
    logic       cpu_tick, tick_led;
    logic [1:0] mode;

    cpu_clock_ctrl #(
        .RATE0(32'd4), .RATE1(32'd6), .RATE2(32'd3), .RATE3(32'd1), .DEBOUNCE_CYCLES(8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .run_sw    (run_sw),
        .step_btn  (step_btn),
        .speed_sel (speed_sel),
        .halt_req  (halt_req),
        .cpu_tick  (cpu_tick),
        .tick_led  (tick_led),
        .mode      (mode)
    );

    always #5 clock = ~clock;

    int rates [4] = '{4, 6, 3, 1};
    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b1;
    // Reference model: mode, RUN cycles since the last period restart, expected outputs, input history.
    int m_mode = 0;
    int m_since = 0;
    bit m_tick = 1'b0;
    bit m_led = 1'b0;
    bit run_h [2];
    bit step_h [3];
    int spd_prev = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        if (chk_en) begin
            check("tick", int'(cpu_tick), int'(m_tick));
            check("led", int'(tick_led), int'(m_led));
            check("mode", int'(mode), m_mode);
        end
    endtask

    // Apply inputs for this cycle and predict the outputs of the next cycle.
    task automatic drive(input bit r, input bit s, input int sp, input bit h);
        bit rs, stp, nt;
        int nm;
        run_sw = r;
        step_btn = s;
        speed_sel = sp[1:0];
        halt_req = h;
        rs = run_h[1];
        stp = step_h[1] & ~step_h[2];
        nt = 1'b0;
        nm = m_mode;
        if (m_mode == 0) begin
            if (rs) begin
                nm = 1;
                m_since = 0;
            end else nt = stp;
        end else if (m_mode == 1) begin
            if (!rs) nm = 0;
            else if (h) nm = 2;
            else if (sp != spd_prev) m_since = 0;
            else begin
                m_since++;
                nt = (m_since % rates[sp]) == 0;
            end
        end else if (!rs) nm = 0;
        m_mode = nm;
        m_tick = nt;
        m_led = m_led ^ nt;
        run_h[1] = run_h[0];
        run_h[0] = r;
        step_h[2] = step_h[1];
        step_h[1] = step_h[0];
        step_h[0] = s;
        spd_prev = sp;
    endtask

    task automatic cyc(input bit r, input bit s, input int sp, input bit h);
        @(negedge clock);
        check_outputs();
        drive(r, s, sp, h);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        check_outputs();
        reset = 1'b1;
        #1;
        check("rst_tick", int'(cpu_tick), 0);
        check("rst_led", int'(tick_led), 0);
        check("rst_mode", int'(mode), 0);
        m_mode = 0; m_since = 0; m_tick = 1'b0; m_led = 1'b0; spd_prev = 0;
        run_h = '{0, 0};
        step_h = '{0, 0, 0};
        @(negedge clock);
        check_outputs();
        reset = 1'b0;
        drive(1'b0, 1'b0, 0, 1'b0);
    endtask

    // Run at speed 0 until the divider of the next cycle equals ph.
    task automatic run_to_phase(input int ph);
        bit found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (m_mode == 1 && m_since % 4 == ph) found = 1'b1;
            else cyc(1'b1, 1'b0, 0, 1'b0);
        end
        check("phase_bound", int'(found), 1);
    endtask

    initial begin
        int n, lat;
        bit r, s, h;
        int sp;
        apply_reset();
        // Free-run at rate 4, then asynchronous reset with divider at 2.
        cyc(1'b1, 1'b0, 0, 1'b0);
        repeat (20) cyc(1'b1, 1'b0, 0, 1'b0);
        run_to_phase(2);
        apply_reset();
        repeat (10) cyc(1'b0, 1'b0, 0, 1'b0);
`ifndef CPU_CLOCK_CTRL_DEBOUNCE_EN
        // Manual step: rise at N gives a single tick at N+3.
        cyc(1'b0, 1'b1, 0, 1'b0);
        lat = -1;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            check_outputs();
            if (cpu_tick && lat < 0) lat = i;
            n += int'(cpu_tick);
            drive(1'b0, i < 5, 0, 1'b0);
        end
        check("step_lat", lat, 3);
        check("step_count", n, 1);
        // run_sw and step arrive together: RUN wins, step dropped.
        repeat (4) cyc(1'b0, 1'b0, 0, 1'b0);
        cyc(1'b1, 1'b1, 0, 1'b0);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b1, 0, 1'b0);
            n += int'(cpu_tick);
        end
        check("coincide_ticks", n, 0);
        check("coincide_mode", int'(mode), 1);
        apply_reset();
`endif
        // Halt on the terminal-count cycle suppresses the tick.
        cyc(1'b1, 1'b0, 0, 1'b0);
        run_to_phase(3);
        cyc(1'b1, 1'b0, 0, 1'b1);
        cyc(1'b1, 1'b0, 0, 1'b0);
        check("halt_tick", int'(cpu_tick), 0);
        check("halt_mode", int'(mode), 2);
        for (int i = 0; i < 10; i++) cyc(1'b1, i % 2 == 0, 0, i == 4);
        repeat (4) cyc(1'b0, 1'b0, 0, 1'b0);
        check("halt_exit", int'(mode), 0);
        // Speed 0 -> 3 mid-count: one gap cycle, then a tick every cycle.
        cyc(1'b1, 1'b0, 0, 1'b0);
        run_to_phase(1);
        cyc(1'b1, 1'b0, 3, 1'b0);
        cyc(1'b1, 1'b0, 3, 1'b0);
        check("spd_gap", int'(cpu_tick), 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 3, 1'b0);
            check("spd_full", int'(cpu_tick), 1);
        end
        // Random traffic against the model.
        apply_reset();
        r = 1'b0; s = 1'b0; sp = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) r = ~r;
`ifndef CPU_CLOCK_CTRL_DEBOUNCE_EN
            if ($urandom_range(0, 3) == 0) s = ~s;
`endif
            if ($urandom_range(0, 49) == 0) sp = int'($urandom_range(0, 3));
            h = $urandom_range(0, 24) == 0;
            cyc(r, s, sp, h);
        end
`ifdef CPU_CLOCK_CTRL_DEBOUNCE_EN
        // Debounced step: a 3-cycle glitch is ignored, a 10-cycle press gives one tick.
        apply_reset();
        chk_en = 1'b0;
        n = 0;
        for (int i = 0; i < 33; i++) begin
            cyc(1'b0, i < 3, 0, 1'b0);
            n += int'(cpu_tick);
        end
        check("glitch_ticks", n, 0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1'b0, i < 10, 0, 1'b0);
            n += int'(cpu_tick);
        end
        check("press_ticks", n, 1);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
